mdio_c45_master: RTL and testbench



---
 rtl/mdio_c45_pkg.sv | 42 ++++
 rtl/mdio_c45_master_if.sv | 25 ++
 rtl/mdio_c45_master_clk_div.sv | 53 +++++
 rtl/mdio_c45_master.sv | 196 +++++++++++++++++++
 tb/tb_mdio_c45_master.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/mdio_c45_pkg.sv
// Shared definitions for the Clause-45 MDIO master.
// Contents: opcode encodings, register word offsets (byte address bits [3:2]),
// frame field widths and constants, and the controller state type.
package mdio_c45_pkg;

   // Clause-45 opcodes as they appear in the frame
   localparam logic [1:0] OP_ADDR     = 2'b00;
   localparam logic [1:0] OP_WRITE    = 2'b01;
   localparam logic [1:0] OP_READ     = 2'b11;
   localparam logic [1:0] OP_READ_INC = 2'b10;

   // Register word offsets (wb_adr_i[3:2])
   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_WDATA  = 2'd1;
   localparam logic [1:0] REG_STATUS = 2'd2;
   localparam logic [1:0] REG_RDATA  = 2'd3;

   // Frame layout
   localparam int         FRAME_W  = 32;
   localparam int         OP_W     = 2;
   localparam int         PRTAD_W  = 5;
   localparam int         DEVAD_W  = 5;
   localparam int         MDATA_W  = 16;
   localparam logic [1:0] ST_C45   = 2'b00;
   localparam logic [1:0] TA_DRIVE = 2'b10;
   // First frame bit (counted from ST) at which a read releases the line
   localparam int         TA_BIT   = 14;
   // First frame bit carrying read data
   localparam int         RD_BIT   = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRE   = 2'd1,
      FRAME = 2'd2
   } state_e;

   // Both read opcodes have op[1] set
   function automatic logic is_read(input logic [1:0] op);
      return op[1];
   endfunction

endpackage

// File: rtl/mdio_c45_master_if.sv
// Wishbone classic slave bus bundle for the MDIO master.
// Signals: wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i[3:0], wb_adr_i[31:0],
// wb_dat_i[31:0] (towards the slave); wb_dat_o[31:0], wb_ack_o, wb_err_o
// (from the slave). Suffixes are named from the slave's point of view.
interface mdio_c45_master_if;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic        wb_we_i;
   logic [3:0]  wb_sel_i;
   logic [31:0] wb_adr_i;
   logic [31:0] wb_dat_i;
   logic [31:0] wb_dat_o;
   logic        wb_ack_o;
   logic        wb_err_o;

   modport slave (
      input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
      output wb_dat_o, wb_ack_o, wb_err_o
   );

   modport master (
      output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
      input  wb_dat_o, wb_ack_o, wb_err_o
   );
endinterface

// File: rtl/mdio_c45_master_clk_div.sv
// MDC generator: counts 0..MDC_DIV-1 while enabled, toggles mdc at the
// terminal count and flags which edge is about to happen.
// Ports: clk_i, rst_n_i (sync, active-low), en_i (low clears counter and
// holds mdc at 0), mdc_o, rise_stb_o / fall_stb_o (high in the cycle whose
// closing clock edge makes mdc rise / fall).
module mdio_clk_div #(
   parameter int MDC_DIV = 50
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic en_i,
   output logic mdc_o,
   output logic rise_stb_o,
   output logic fall_stb_o
);

   localparam int DW = (MDC_DIV > 1) ? $clog2(MDC_DIV) : 1;

   logic [DW-1:0] cnt_q, cnt_d;
   logic          mdc_q, mdc_d;
   logic          tc;

   assign tc = (cnt_q == DW'(MDC_DIV - 1));

   always_comb begin
      cnt_d = cnt_q;
      mdc_d = mdc_q;
      if (!en_i) begin
         cnt_d = '0;
         mdc_d = 1'b0;
      end else if (tc) begin
         cnt_d = '0;
         mdc_d = ~mdc_q;
      end else begin
         cnt_d = cnt_q + DW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
         mdc_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         mdc_q <= mdc_d;
      end
   end

   assign mdc_o      = mdc_q;
   assign rise_stb_o = en_i & tc & ~mdc_q;
   assign fall_stb_o = en_i & tc &  mdc_q;

endmodule

// File: rtl/mdio_c45_master.sv
// Wishbone-controlled Clause-45 MDIO frame master for the SFP+ mezzanine.
// Ports: wb_clk_i, wb_rst_n_i (sync, active-low); wb (wishbone slave
// bundle: CTRL/WDATA/STATUS/RDATA registers at 0x0/0x4/0x8/0xC);
// mdc, mdo, mdo_t (1 = release line), mdi (muxed input), mdio_sel (port).
// A frame is PREAMBLE_LEN ones followed by {ST,op,prtad,devad,TA,data}.
module mdio_c45_master
   import mdio_c45_pkg::*;
#(
   parameter int MDC_DIV      = 50,
   parameter int PREAMBLE_LEN = 32
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_n_i,
   mdio_c45_master_if.slave    wb,
   output logic                mdc,
   output logic                mdo,
   output logic                mdo_t,
   input  logic                mdi,
   output logic                mdio_sel
);

   if (MDC_DIV < 2) begin : g_bad_div
      $error("mdio_c45_master: MDC_DIV must be at least 2");
   end
   if (PREAMBLE_LEN < 1) begin : g_bad_pre
      $error("mdio_c45_master: PREAMBLE_LEN must be at least 1");
   end

   localparam int CNT_MAX = (PREAMBLE_LEN > FRAME_W) ? PREAMBLE_LEN : FRAME_W;
   localparam int CNT_W   = $clog2(CNT_MAX);

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [FRAME_W-1:0]    sr_q, sr_d;
   logic [MDATA_W-1:0]    rx_q, rx_d;
   logic [MDATA_W-1:0]    rdata_q, rdata_d;
   logic [MDATA_W-1:0]    wdata_q, wdata_d;
   logic                  rd_q, rd_d;
   logic                  done_q, done_d;
   logic                  sel_q, sel_d;
   logic                  mdo_q, mdo_d;
   logic                  mdo_t_q, mdo_t_d;
   logic                  ack_q, ack_d;
   logic [31:0]           dat_q, dat_d;

   logic                  busy, acc, wr;
   logic [1:0]            idx;
   logic                  rise_stb, fall_stb;
   logic                  unused;

   assign busy = (state_q != IDLE);
   assign acc  = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
   assign wr   = acc & wb.wb_we_i;
   assign idx  = wb.wb_adr_i[3:2];

   // Byte selects and undecoded address/data bits are intentionally ignored
   assign unused = ^{wb.wb_sel_i, wb.wb_adr_i[31:4], wb.wb_adr_i[1:0],
                     wb.wb_dat_i[31:16]};

   mdio_clk_div #(.MDC_DIV(MDC_DIV)) u_div (
      .clk_i      (wb_clk_i),
      .rst_n_i    (wb_rst_n_i),
      .en_i       (busy),
      .mdc_o      (mdc),
      .rise_stb_o (rise_stb),
      .fall_stb_o (fall_stb)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sr_d    = sr_q;
      rx_d    = rx_q;
      rdata_d = rdata_q;
      wdata_d = wdata_q;
      rd_d    = rd_q;
      done_d  = done_q;
      sel_d   = sel_q;
      mdo_d   = mdo_q;
      mdo_t_d = mdo_t_q;
      ack_d   = acc;
      dat_d   = dat_q;

      // Read data is captured from pre-edge register values
      if (acc) begin
         case (idx)
            REG_WDATA:  dat_d = {16'h0, wdata_q};
            REG_STATUS: dat_d = {30'h0, done_q, busy};
            REG_RDATA:  dat_d = {16'h0, rdata_q};
            default:    dat_d = 32'h0;
         endcase
      end

      if (wr && idx == REG_WDATA) begin
         wdata_d = wb.wb_dat_i[15:0];
      end

      case (state_q)
         IDLE: begin
            if (wr && idx == REG_CTRL) begin
               state_d = PRE;
               cnt_d   = '0;
               sr_d    = {ST_C45, wb.wb_dat_i[1:0], wb.wb_dat_i[7:3],
                          wb.wb_dat_i[12:8], TA_DRIVE, wdata_q};
               rd_d    = is_read(wb.wb_dat_i[1:0]);
               sel_d   = wb.wb_dat_i[2];
               done_d  = 1'b0;
               rx_d    = '0;
               mdo_d   = 1'b1;
               mdo_t_d = 1'b0;
            end
         end

         PRE: begin
            if (fall_stb) begin
               if (cnt_q == CNT_W'(PREAMBLE_LEN - 1)) begin
                  state_d = FRAME;
                  cnt_d   = '0;
                  mdo_d   = sr_q[FRAME_W-1];
                  sr_d    = {sr_q[FRAME_W-2:0], 1'b0};
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end

         FRAME: begin
            // cnt_q holds the index of the frame bit currently on the line
            if (rise_stb && rd_q && cnt_q >= CNT_W'(RD_BIT)) begin
               rx_d = {rx_q[MDATA_W-2:0], mdi};
            end
            if (fall_stb) begin
               if (cnt_q == CNT_W'(FRAME_W - 1)) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
                  mdo_d   = 1'b1;
                  mdo_t_d = 1'b1;
                  if (rd_q) begin
                     rdata_d = rx_q;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
                  mdo_d = sr_q[FRAME_W-1];
                  sr_d  = {sr_q[FRAME_W-2:0], 1'b0};
                  // Release the line when entering the turnaround bit
                  if (rd_q && cnt_q >= CNT_W'(TA_BIT - 1)) begin
                     mdo_t_d = 1'b1;
                  end
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sr_q    <= '0;
         rx_q    <= '0;
         rdata_q <= '0;
         wdata_q <= '0;
         rd_q    <= 1'b0;
         done_q  <= 1'b0;
         sel_q   <= 1'b0;
         mdo_q   <= 1'b1;
         mdo_t_q <= 1'b1;
         ack_q   <= 1'b0;
         dat_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sr_q    <= sr_d;
         rx_q    <= rx_d;
         rdata_q <= rdata_d;
         wdata_q <= wdata_d;
         rd_q    <= rd_d;
         done_q  <= done_d;
         sel_q   <= sel_d;
         mdo_q   <= mdo_d;
         mdo_t_q <= mdo_t_d;
         ack_q   <= ack_d;
         dat_q   <= dat_d;
      end
   end

   assign wb.wb_ack_o = ack_q;
   assign wb.wb_dat_o = dat_q;
   assign wb.wb_err_o = 1'b0;
   assign mdo         = mdo_q;
   assign mdo_t       = mdo_t_q;
   assign mdio_sel    = sel_q;

endmodule

// File: tb/tb_mdio_c45_master.sv
// Bench for mdio_c45_master with MDC_DIV=4, PREAMBLE_LEN=32 (512-cycle ops).
module tb_mdio_c45_master;
   import mdio_c45_pkg::*;

   localparam int DIV   = 4;
   localparam int PRE   = 32;
   localparam int OPLEN = (PRE + 32) * 2 * DIV;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic mdi   = 1'b0;
   logic mdc, mdo, mdo_t, mdio_sel;

   mdio_c45_master_if wbif();

   mdio_c45_master #(.MDC_DIV(DIV), .PREAMBLE_LEN(PRE)) dut (
      .wb_clk_i   (clk),
      .wb_rst_n_i (rst_n),
      .wb         (wbif.slave),
      .mdc        (mdc),
      .mdo        (mdo),
      .mdo_t      (mdo_t),
      .mdi        (mdi),
      .mdio_sel   (mdio_sel)
   );

   always #5 clk = ~clk;

   int          errors = 0;
   int          checks = 0;
   int unsigned cyc_cnt = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // Line monitor and PHY model
   bit          mon_en  = 1'b0;
   bit          sel_chk = 1'b0;
   logic        exp_sel = 1'b0;
   int          rises   = 0;
   int          sel_err = 0;
   logic [63:0] cap_mdo = '0;
   logic [63:0] cap_t   = '0;
   logic [15:0] phy_word = '0;
   logic        prev_mdc = 1'b0;
   logic [15:0] last_rdata = '0;

   always @(negedge clk) begin : mon
      int f;
      if (mon_en) begin
         if (mdc && !prev_mdc) begin
            if (rises < 64) begin
               cap_mdo[63-rises] = mdo;
               cap_t[63-rises]   = mdo_t;
            end
            rises++;
         end
         if (sel_chk && mdio_sel !== exp_sel) sel_err++;
         // Drive the bit for the period whose low phase is now current
         f = rises - PRE;
         if (f >= 16 && f <= 31) mdi = phy_word[31-f];
         else                    mdi = 1'(($urandom_range(0, 1)));
      end
      prev_mdc = mdc;
   end

   // All tasks start and end just after a rising edge with ack low
   task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input string nm);
      wbif.wb_cyc_i = 1'b1; wbif.wb_stb_i = 1'b1; wbif.wb_we_i = 1'b1;
      wbif.wb_adr_i = a;    wbif.wb_dat_i = d;
      @(posedge clk); #1;
      checks++;
      if (wbif.wb_ack_o !== 1'b1) begin
         errors++;
         $display("FAIL %s ack: got %b required 1 one cycle after stb", nm, wbif.wb_ack_o);
      end
      wbif.wb_cyc_i = 1'b0; wbif.wb_stb_i = 1'b0; wbif.wb_we_i = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
      wbif.wb_cyc_i = 1'b1; wbif.wb_stb_i = 1'b1; wbif.wb_we_i = 1'b0;
      wbif.wb_adr_i = a;
      @(posedge clk); #1;
      checks++;
      if (wbif.wb_ack_o !== 1'b1) begin
         errors++;
         $display("FAIL read_ack addr=%h: got %b required 1", a, wbif.wb_ack_o);
      end
      d = wbif.wb_dat_o;
      wbif.wb_cyc_i = 1'b0; wbif.wb_stb_i = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic check32(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", nm, got, exp);
      end
   endtask

   task automatic wait_to(input int unsigned t0, input int j);
      while (int'(cyc_cnt - t0) < j) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic check_idle_lines(input string nm, input logic sel);
      check32({nm, "_mdc"},   {31'h0, mdc},      32'h0);
      check32({nm, "_mdo"},   {31'h0, mdo},      32'h1);
      check32({nm, "_mdo_t"}, {31'h0, mdo_t},    32'h1);
      check32({nm, "_sel"},   {31'h0, mdio_sel}, {31'h0, sel});
   endtask

   // Runs one complete op and checks the whole frame against the model
   task automatic run_op(input string nm, input logic [1:0] op, input logic port,
                         input logic [4:0] prtad, input logic [4:0] devad,
                         input logic [15:0] wdata, input logic [15:0] phy, input bit mid);
      logic [31:0] frame, ctrl, rd;
      logic [63:0] exp_mdo, exp_t;
      int unsigned t0;
      bit          is_rd;
      is_rd   = (op == OP_READ || op == OP_READ_INC);
      frame   = (32'(op) << 28) | (32'(prtad) << 23) | (32'(devad) << 18) |
                (32'h2 << 16) | 32'(wdata);
      exp_mdo = {32'hFFFF_FFFF, frame};
      exp_t   = is_rd ? 64'h3_FFFF : 64'h0;
      ctrl    = (32'(devad) << 8) | (32'(prtad) << 3) | (32'(port) << 2) | 32'(op);

      wb_write(32'h4, {16'h0, wdata}, {nm, "_wdata"});
      rises = 0; cap_mdo = '0; cap_t = '0; phy_word = phy;
      exp_sel = port; sel_err = 0; mon_en = 1'b1;
      wb_write(32'h0, ctrl, {nm, "_ctrl"});
      t0 = cyc_cnt - 1;
      sel_chk = 1'b1;
      if (mid) begin
         wait_to(t0, 100);
         wb_write(32'h0, ctrl ^ 32'h0000_1F07, {nm, "_busy_ctrl"});
      end
      wait_to(t0, OPLEN - 2);
      wb_read(32'h8, rd);
      check32({nm, "_status_last_busy"}, rd, 32'h1);
      wb_read(32'h8, rd);
      check32({nm, "_status_done"}, rd, 32'h2);
      mon_en = 1'b0; sel_chk = 1'b0;
      check_idle_lines({nm, "_end"}, port);
      check32({nm, "_rises"}, 32'(rises), 32'd64);
      check32({nm, "_sel_stable"}, 32'(sel_err), 32'h0);
      check32({nm, "_mdo_t_hi"}, cap_t[63:32], exp_t[63:32]);
      check32({nm, "_mdo_t_lo"}, cap_t[31:0],  exp_t[31:0]);
      check32({nm, "_preamble"}, cap_mdo[63:32], exp_mdo[63:32]);
      check32({nm, "_frame"}, cap_mdo[31:0] & ~exp_t[31:0], exp_mdo[31:0] & ~exp_t[31:0]);
      if (is_rd) last_rdata = phy;
      wb_read(32'hC, rd);
      check32({nm, "_rdata"}, rd, {16'h0, last_rdata});
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      rst_n = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check_idle_lines("reset", 1'b0);
      check32("reset_ack", {31'h0, wbif.wb_ack_o}, 32'h0);
      check32("reset_dat", wbif.wb_dat_o, 32'h0);
      check32("reset_err", {31'h0, wbif.wb_err_o}, 32'h0);
      wb_read(32'h8, rd); check32("reset_status", rd, 32'h0);
      wb_read(32'hC, rd); check32("reset_rdata", rd, 32'h0);
      wb_read(32'h4, rd); check32("reset_wdata", rd, 32'h0);
   endtask

   task automatic test_ack_pulse();
      logic [3:0] seen;
      wbif.wb_cyc_i = 1'b1; wbif.wb_stb_i = 1'b1; wbif.wb_we_i = 1'b0;
      wbif.wb_adr_i = 32'h8;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         seen[3-i] = wbif.wb_ack_o;
      end
      wbif.wb_cyc_i = 1'b0; wbif.wb_stb_i = 1'b0;
      @(posedge clk); #1;
      check32("ack_pulse_pattern", {28'h0, seen}, 32'hA);
   endtask

   task automatic test_ro_write();
      logic [31:0] rd;
      wb_write(32'h8, 32'hFFFF_FFFF, "ro_status_wr");
      wb_write(32'hC, 32'h0000_1111, "ro_rdata_wr");
      wb_read(32'hC, rd); check32("ro_rdata_kept", rd, {16'h0, last_rdata});
      wb_read(32'h8, rd); check32("ro_status_kept", rd, 32'h2);
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd;
      int unsigned t0;
      wb_write(32'h4, 32'h0, "rst_wdata");
      wb_write(32'h0, (32'h1 << 8) | (32'h1 << 2) | 32'(OP_READ), "rst_ctrl");
      t0 = cyc_cnt - 1;
      wait_to(t0, 300);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check_idle_lines("rst_mid", 1'b0);
      check32("rst_mid_ack", {31'h0, wbif.wb_ack_o}, 32'h0);
      check32("rst_mid_dat", wbif.wb_dat_o, 32'h0);
      last_rdata = '0;
      wb_read(32'h8, rd); check32("rst_mid_status", rd, 32'h0);
      wb_read(32'hC, rd); check32("rst_mid_rdata", rd, 32'h0);
      run_op("after_rst", OP_READ, 1'b0, 5'h07, 5'h01, 16'h0, 16'h5A3C, 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 4; i++) begin
         run_op($sformatf("rand%0d", i), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                5'($urandom), 5'($urandom), 16'($urandom), 16'($urandom), 1'b0);
      end
   endtask

   initial begin
      wbif.wb_cyc_i = 1'b0; wbif.wb_stb_i = 1'b0; wbif.wb_we_i = 1'b0;
      wbif.wb_sel_i = 4'hF; wbif.wb_adr_i = '0;   wbif.wb_dat_i = '0;
      @(posedge clk); #1;
      test_reset();
      test_ack_pulse();
      run_op("addr",  OP_ADDR,  1'b0, 5'h00, 5'h02, 16'h1234, 16'h0, 1'b0);
      run_op("write", OP_WRITE, 1'b1, 5'h03, 5'h1E, 16'hBEEF, 16'h0, 1'b0);
      run_op("read",  OP_READ,  1'b0, 5'h01, 5'h01, 16'h0, 16'hA5C3, 1'b0);
      test_ro_write();
      run_op("busy_wr", OP_READ_INC, 1'b1, 5'h11, 5'h05, 16'h0, 16'h3C96, 1'b1);
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
